// File: rtl/fp_class_pkg.sv
// rtl/fp_class_pkg.sv - shared class-flag indices and format helper functions
package fp_class_pkg;

  localparam int FLAGW       = 6;
  localparam int F_NORMAL    = 0;
  localparam int F_SUBNORMAL = 1;
  localparam int F_ZERO      = 2;
  localparam int F_INF       = 3;
  localparam int F_QNAN      = 4;
  localparam int F_SNAN      = 5;

  function automatic int bias(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  function automatic int emin(input int nexp);
    return 1 - bias(nexp);
  endfunction

  // Wide enough to hold NSIG+1, the largest subnormal shift plus headroom.
  function automatic int shw(input int nsig);
    return $clog2(nsig + 2);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational priority-encoder leading-zero counter
module fp_lzc #(
  parameter int W = 7,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    cnt  = CW'(W);
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (d[i]) begin
        cnt  = CW'(W - 1 - i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_class_norm_pipe.sv
// rtl/fp_class_norm_pipe.sv - 2-stage FP operand classifier/normaliser with handshake
module fp_class_norm_pipe
  import fp_class_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7,
  parameter int TAGW = 4,
  parameter int CNTW = 16,
  localparam int SHW = shw(NSIG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_data,
  input  logic [TAGW-1:0]        in_tag,
  input  logic                   daz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [NSIG:0]          out_sig,
  output logic signed [NEXP+1:0] out_exp,
  output logic [SHW-1:0]         out_shift,
  output logic [FLAGW-1:0]       out_flags,
  output logic [TAGW-1:0]        out_tag,
  input  logic                   cnt_clr,
  output logic [CNTW-1:0]        cnt_nan,
  output logic [CNTW-1:0]        cnt_sub
);

  localparam int W   = NEXP + NSIG + 1;
  localparam int EW  = NEXP + 2;
  localparam int LZW = $clog2(NSIG + 1);

  localparam logic signed [EW-1:0] BIAS_E = EW'(bias(NEXP));
  localparam logic signed [EW-1:0] EMIN_E = EW'(emin(NEXP));
  localparam logic signed [EW-1:0] EINF_E = EW'(bias(NEXP) + 1);

  function automatic logic [FLAGW-1:0] classify(input logic [NEXP-1:0] e,
                                                input logic [NSIG-1:0] f,
                                                input logic            z);
    logic ones, zeros, fz;
    ones  = &e;
    zeros = ~|e;
    fz    = ~|f;
    classify              = '0;
    classify[F_NORMAL]    = !ones && !zeros;
    classify[F_SUBNORMAL] = zeros && !fz && !z;
    classify[F_ZERO]      = zeros && (fz || z);
    classify[F_INF]       = ones && fz;
    classify[F_QNAN]      = ones && f[NSIG-1];
    classify[F_SNAN]      = ones && !f[NSIG-1] && !fz;
  endfunction

  logic             s1_valid, s2_valid;
  logic [W-1:0]     s1_data;
  logic [TAGW-1:0]  s1_tag;
  logic             s1_daz;
  logic             s1_advance, accept;
  logic [FLAGW-1:0] in_flags, s1_flags;
  logic [NEXP-1:0]  s1_exp;
  logic [NSIG-1:0]  s1_frac;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid;

  assign s1_exp   = s1_data[W-2:NSIG];
  assign s1_frac  = s1_data[NSIG-1:0];
  // Counters need the class at the accept edge; stage 2 reclassifies from the held copy.
  assign in_flags = classify(in_data[W-2:NSIG], in_data[NSIG-1:0], daz);
  assign s1_flags = classify(s1_exp, s1_frac, s1_daz);

  logic [LZW-1:0]       lz;
  logic                 lz_zero;
  logic [NSIG:0]        n_sig;
  logic signed [EW-1:0] n_exp;
  logic [SHW-1:0]       n_shift;
  logic [NSIG-1:0]      frac_sh;

  fp_lzc #(.W(NSIG)) u_lzc (
    .d    (s1_frac),
    .cnt  (lz),
    .zero (lz_zero)
  );

  always_comb begin
    n_sig   = '0;
    n_exp   = '0;
    n_shift = '0;
    frac_sh = '0;
    if (s1_flags[F_NORMAL]) begin
      n_sig = {1'b1, s1_frac};
      n_exp = $signed({2'b00, s1_exp}) - BIAS_E;
    end else if (s1_flags[F_SUBNORMAL] && !lz_zero) begin
      n_shift = SHW'(lz) + SHW'(1);
      frac_sh = s1_frac << n_shift;
      n_sig   = {1'b1, frac_sh};
      n_exp   = EMIN_E - $signed(EW'(n_shift));
    end else if (s1_flags[F_INF] || s1_flags[F_QNAN] || s1_flags[F_SNAN]) begin
      n_sig = {1'b1, s1_frac};
      n_exp = EINF_E;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_data   <= '0;
      s1_tag    <= '0;
      s1_daz    <= 1'b0;
      out_sign  <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_shift <= '0;
      out_flags <= FLAGW'(1) << F_ZERO;
      out_tag   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_tag  <= in_tag;
          s1_daz  <= daz;
        end
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_sign  <= s1_data[W-1];
          out_sig   <= n_sig;
          out_exp   <= n_exp;
          out_shift <= n_shift;
          out_flags <= s1_flags;
          out_tag   <= s1_tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_nan <= '0;
      cnt_sub <= '0;
    end else if (accept) begin
      if ((in_flags[F_QNAN] || in_flags[F_SNAN]) && !(&cnt_nan))
        cnt_nan <= cnt_nan + CNTW'(1);
      // DAZ-flushed operands still count as subnormal events.
      if (~|in_data[W-2:NSIG] && |in_data[NSIG-1:0] && !(&cnt_sub))
        cnt_sub <= cnt_sub + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fp_class_norm_pipe.sv
// tb/tb_fp_class_norm_pipe.sv - scoreboard bench for fp_class_norm_pipe in bf16 with 2-bit counters
module tb_fp_class_norm_pipe;

  typedef struct {
    logic [15:0]       d;
    logic              z;
    logic [3:0]        t;
    logic              s;
    logic [7:0]        sig;
    logic signed [9:0] e;
    logic [3:0]        sh;
    logic [5:0]        f;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, daz, out_valid, out_ready, cnt_clr;
  logic [15:0]       in_data;
  logic [3:0]        in_tag, out_tag, out_shift;
  logic              out_sign;
  logic [7:0]        out_sig;
  logic signed [9:0] out_exp;
  logic [5:0]        out_flags;
  logic [1:0]        cnt_nan, cnt_sub;

  always #5 clk = ~clk;

  fp_class_norm_pipe #(.NEXP(8), .NSIG(7), .TAGW(4), .CNTW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .daz       (daz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_sig   (out_sig),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_flags (out_flags),
    .out_tag   (out_tag),
    .cnt_clr   (cnt_clr),
    .cnt_nan   (cnt_nan),
    .cnt_sub   (cnt_sub)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  int   m_nan = 0;
  int   m_sub = 0;

  function automatic vec_t mk(input logic [15:0] d, input logic z, input logic [3:0] t,
                              input logic s, input logic [7:0] sig, input int e,
                              input int sh, input logic [5:0] f);
    vec_t v;
    v.d = d; v.z = z; v.t = t; v.s = s; v.sig = sig;
    v.e = 10'(e); v.sh = 4'(sh); v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Outputs are compared against the head expectation on every valid cycle, so a stall
  // that disturbs held outputs shows up; the head is retired only on a real transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(sb.size()), 64'd1);
      end else begin
        chk($sformatf("result_tag%0d", sb[0].t),
            {31'd0, out_sign, out_sig, out_exp, out_shift, out_flags, out_tag},
            {31'd0, sb[0].s, sb[0].sig, sb[0].e, sb[0].sh, sb[0].f, sb[0].t});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input vec_t v);
    int   n;
    logic acc;
    in_valid = 1'b1; in_data = v.d; in_tag = v.t; daz = v.z;
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        sb.push_back(v);
        if (cnt_clr) begin
          m_nan = 0; m_sub = 0;
        end else begin
          if (v.f[4] || v.f[5]) m_nan = (m_nan < 3) ? m_nan + 1 : 3;
          if (v.d[14:7] == 8'd0 && v.d[6:0] != 7'd0) m_sub = (m_sub < 3) ? m_sub + 1 : 3;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_cnt_nan"}, 64'(cnt_nan), 64'(m_nan));
    chk({name, "_cnt_sub"}, 64'(cnt_sub), 64'(m_sub));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; daz = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", {31'd0, out_sign, out_sig, out_exp, out_shift, out_flags, out_tag},
        {31'd0, 1'b0, 8'h00, 10'd0, 4'd0, 6'b000100, 4'd0});
    chk("reset_cnt", {cnt_nan, cnt_sub}, 4'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept edge loads stage 1, the next edge presents the result.
    send(mk(16'h3F80, 0, 4'd1, 0, 8'h80, 0, 0, 6'b000001));
    @(negedge clk);
    chk("latency_one_edge", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_two_edges", 64'(out_valid), 64'd1);
    drain();

    send(mk(16'h0001, 0, 4'd2, 0, 8'h80, -133, 7, 6'b000010));
    drain();
    chk_cnt("after_sub1");
    chk("cnt_sub_is_one", 64'(cnt_sub), 64'd1);

    send(mk(16'h0040, 0, 4'd3, 0, 8'h80, -127, 1, 6'b000010));
    send(mk(16'h8001, 1, 4'd4, 1, 8'h00, 0, 0, 6'b000100));
    drain();
    chk_cnt("after_daz");

    send(mk(16'h7F80, 0, 4'd5, 0, 8'h80, 128, 0, 6'b001000));
    send(mk(16'h7FC0, 0, 4'd6, 0, 8'hC0, 128, 0, 6'b010000));
    send(mk(16'h7F81, 0, 4'd7, 0, 8'h81, 128, 0, 6'b100000));
    drain();
    chk_cnt("after_special");
    chk("cnt_nan_is_two", 64'(cnt_nan), 64'd2);

    send(mk(16'hC0A0, 0, 4'd8,  1, 8'hA0, 2,    0, 6'b000001));
    send(mk(16'h0000, 0, 4'd9,  0, 8'h00, 0,    0, 6'b000100));
    send(mk(16'h8000, 0, 4'd10, 1, 8'h00, 0,    0, 6'b000100));
    send(mk(16'h0055, 0, 4'd11, 0, 8'hAA, -127, 1, 6'b000010));
    send(mk(16'h0015, 0, 4'd12, 0, 8'hA8, -129, 3, 6'b000010));
    send(mk(16'hFF80, 0, 4'd13, 1, 8'h80, 128,  0, 6'b001000));
    send(mk(16'h7F7F, 0, 4'd14, 0, 8'hFF, 127,  0, 6'b000001));
    send(mk(16'h3F80, 1, 4'd15, 0, 8'h80, 0,    0, 6'b000001));
    drain();

    send(mk(16'h7FC0, 0, 4'd0, 0, 8'hC0, 128, 0, 6'b010000));
    send(mk(16'hFFC1, 0, 4'd1, 1, 8'hC1, 128, 0, 6'b010000));
    send(mk(16'h7F81, 0, 4'd2, 0, 8'h81, 128, 0, 6'b100000));
    send(mk(16'h7FFF, 0, 4'd3, 0, 8'hFF, 128, 0, 6'b010000));
    send(mk(16'hFF90, 0, 4'd4, 1, 8'h90, 128, 0, 6'b100000));
    drain();
    chk_cnt("after_saturate");
    chk("cnt_nan_saturated", 64'(cnt_nan), 64'd3);

    // Stall: two operands fill the pipe, the third waits until the consumer returns.
    out_ready = 1'b0;
    send(mk(16'h4000, 0, 4'd8,  0, 8'h80, 1,    0, 6'b000001));
    send(mk(16'h0002, 0, 4'd9,  0, 8'h80, -132, 6, 6'b000010));
    fork
      send(mk(16'hBF00, 0, 4'd10, 1, 8'h80, -1, 0, 6'b000001));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    cnt_clr = 1'b1;
    send(mk(16'h7FC0, 0, 4'd5, 0, 8'hC0, 128, 0, 6'b010000));
    cnt_clr = 1'b0;
    drain();
    chk_cnt("after_clr");
    chk("cnt_clr_wins", {cnt_nan, cnt_sub}, 4'd0);

    out_ready = 1'b0;
    send(mk(16'h0001, 0, 4'd1, 0, 8'h80, -133, 7, 6'b000010));
    send(mk(16'h7FC0, 0, 4'd2, 0, 8'hC0, 128,  0, 6'b010000));
    @(negedge clk);
    chk_cnt("pipe_full");
    chk("pipe_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h7FC0; in_tag = 4'd3; daz = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.delete();
    m_nan = 0; m_sub = 0;
    chk("rst_full_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full_in_ready", 64'(in_ready), 64'd1);
    chk_cnt("rst_full");
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(mk(16'hBF80, 0, 4'd6, 1, 8'h80, 0, 0, 6'b000001));
    drain();
    chk_cnt("post_reset");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
